snake_tick_scheduler: RTL

Game-rate scheduler for the snake core. Clocked by the 25 MHz pixel clock from the clock divider. Counts a programmable move period and waits for the next VGA vertical-blank edge, so each grid update lands outside active video. Then it hands one update request to the game logic and holds it until the logic acknowledges. Each eaten food item shortens the move period, down to a floor.

---
 rtl/snake_pkg.sv | 24 ++
 rtl/snake_tick_scheduler_if.sv | 29 ++
 rtl/snake_tick_scheduler_rise_detect.sv | 29 ++
 rtl/snake_tick_scheduler.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg
// Shared definitions for the snake game blocks.
//   - STATE_W / state_e : scheduler FSM encoding (IDLE=0, RUN=1, ARMED=2,
//                         UPDATE=3, HALT=4), also shown on debug LEDs.
//   - SNAKE_*           : default move timing in clk_in cycles at 25 MHz,
//                         reusable by any block that needs the game rate.
package snake_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        ARMED  = 3'd2,
        UPDATE = 3'd3,
        HALT   = 3'd4
    } state_e;

    // 0.5 s initial move period, 20 ms speed-up per food item, 0.1 s floor.
    localparam int unsigned SNAKE_BASE_PERIOD = 12_500_000;
    localparam int unsigned SNAKE_STEP        = 500_000;
    localparam int unsigned SNAKE_MIN_PERIOD  = 2_500_000;

endpackage

// File: rtl/snake_tick_scheduler_if.sv
// snake_tick_scheduler_if
// Handshake between the tick scheduler and the game logic.
//   update_req  : scheduler -> game, one move requested, held until update_done
//   update_done : game -> scheduler, single-cycle acknowledge of a move
//   food_eaten  : game -> scheduler, single-cycle pulse, speeds the game up
//   game_over   : game -> scheduler, single-cycle pulse, stops scheduling
// master = scheduler side, slave = game logic side.
interface snake_tick_scheduler_if;

    logic update_req;
    logic update_done;
    logic food_eaten;
    logic game_over;

    modport master (
        output update_req,
        input  update_done,
        input  food_eaten,
        input  game_over
    );

    modport slave (
        input  update_req,
        output update_done,
        output food_eaten,
        output game_over
    );

endinterface

// File: rtl/snake_tick_scheduler_rise_detect.sv
// rise_detect
// One-flop rising-edge detector for a level that is already synchronous to
// clk_in (vblank here, debounced buttons elsewhere).
//   clk_in : clock
//   reset  : synchronous, active-high; clears the history flop
//   din    : level input
//   rise   : high in the cycle where din=1 and the previous-cycle din was 0
module rise_detect (
    input  logic clk_in,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q_reg;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            din_q_reg <= 1'b0;
        end else begin
            din_q_reg <= din;
        end
    end

    // Compared against the live input so the FSM can act on the edge in the
    // same cycle it appears.
    assign rise = din & ~din_q_reg;

endmodule

// File: rtl/snake_tick_scheduler.sv
// snake_tick_scheduler
// Game-rate scheduler: counts a programmable move period, then waits for the
// next vblank rising edge so the grid update lands outside active video, then
// raises update_req until the game logic acknowledges. Each food item shortens
// the period by STEP, saturating at MIN_PERIOD.
//   clk_in  : 25 MHz pixel clock, only clock
//   reset   : synchronous, active-high
//   start   : pulse, leaves IDLE/HALT and restarts at BASE_PERIOD
//   pause   : level, freezes the period counter while in RUN
//   vblank  : level from the VGA sync generator
//   game    : handshake with the game logic (update_req/update_done,
//             food_eaten, game_over)
//   period  : current move period
//   moves   : completed updates, wraps at 16 bits
//   state   : FSM state for debug/LEDs
module snake_tick_scheduler
    import snake_pkg::*;
#(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned BASE_PERIOD = SNAKE_BASE_PERIOD,
    parameter int unsigned STEP        = SNAKE_STEP,
    parameter int unsigned MIN_PERIOD  = SNAKE_MIN_PERIOD
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       vblank,
    snake_tick_scheduler_if.master     game,
    output logic [CNT_W-1:0]           period,
    output logic [15:0]                moves,
    output logic [STATE_W-1:0]         state
);

    localparam logic [CNT_W-1:0] BASE_P = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W:0]   STEP_W = (CNT_W+1)'(STEP);
    localparam logic [CNT_W:0]   MIN_W  = (CNT_W+1)'(MIN_PERIOD);

    state_e             state_reg;
    logic [CNT_W-1:0]   counter_reg;
    logic [CNT_W-1:0]   period_reg;
    logic [15:0]        moves_reg;
    logic               update_req_reg;

    logic               vblank_rise;
    logic [CNT_W:0]     period_diff;
    logic [CNT_W-1:0]   period_next;
    logic               period_expired;

    rise_detect u_vblank_rise (
        .clk_in (clk_in),
        .reset  (reset),
        .din    (vblank),
        .rise   (vblank_rise)
    );

    // Saturating decrement: the extra MSB of the difference flags a borrow,
    // so a period smaller than STEP clamps to the floor instead of wrapping.
    always_comb begin
        period_diff = {1'b0, period_reg} - STEP_W;
        period_next = period_reg;
        if (period_diff[CNT_W] || (period_diff < MIN_W)) begin
            period_next = MIN_W[CNT_W-1:0];
        end else begin
            period_next = period_diff[CNT_W-1:0];
        end
    end

    // >= rather than == because a food pulse can shrink the period below the
    // count already reached; the move then fires on the next unpaused edge.
    assign period_expired = (counter_reg >= (period_reg - CNT_W'(1)));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg      <= IDLE;
            counter_reg    <= '0;
            period_reg     <= BASE_P;
            moves_reg      <= '0;
            update_req_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, HALT: begin
                    // Outputs stay frozen here so the final score/speed
                    // remain visible after a game over.
                    if (start) begin
                        state_reg   <= RUN;
                        counter_reg <= '0;
                        period_reg  <= BASE_P;
                        moves_reg   <= '0;
                    end
                end

                RUN, ARMED, UPDATE: begin
                    if (game.game_over) begin
                        // Highest-priority event: abandon any in-flight move.
                        state_reg      <= HALT;
                        counter_reg    <= '0;
                        update_req_reg <= 1'b0;
                    end else begin
                        // Food is independent of the move handshake, so it
                        // coexists with update_done in the same cycle.
                        if (game.food_eaten) begin
                            period_reg <= period_next;
                        end

                        case (state_reg)
                            RUN: begin
                                if (!pause) begin
                                    if (period_expired) begin
                                        counter_reg <= '0;
                                        state_reg   <= ARMED;
                                    end else begin
                                        counter_reg <= counter_reg + CNT_W'(1);
                                    end
                                end
                            end

                            ARMED: begin
                                // Only a fresh edge counts; entering with
                                // vblank already high waits a whole frame.
                                if (vblank_rise) begin
                                    state_reg      <= UPDATE;
                                    update_req_reg <= 1'b1;
                                end
                            end

                            UPDATE: begin
                                // pause is deliberately not looked at here:
                                // a started move always finishes.
                                if (game.update_done) begin
                                    update_req_reg <= 1'b0;
                                    moves_reg      <= moves_reg + 16'd1;
                                    state_reg      <= RUN;
                                end
                            end

                            default: begin
                            end
                        endcase
                    end
                end

                default: begin
                    // Unreachable encodings fall back to a safe idle.
                    state_reg      <= IDLE;
                    counter_reg    <= '0;
                    update_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign game.update_req = update_req_reg;
    assign period          = period_reg;
    assign moves           = moves_reg;
    assign state           = state_reg;

endmodule
